ahb_burst_master: RTL and testbench

//  AHB-Lite bus master sequencer: accepts one transfer command (addr, burst, size, dir),

---
 rtl/ahb_burst_master.sv | 241 ++++++++++++++++++++++++
 tb/tb_ahb_burst_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_master.sv
// ---------------------------------------------------------------------------
// ahb_burst_master
//   AHB-Lite bus master sequencer. Takes one transfer command at a time
//   (start address, burst type, size, direction), then drives the pipelined
//   address/data phases (NONSEQ then SEQ) and honours HREADY wait states.
//   It generates INCR and WRAP addresses and handles the two-cycle ERROR
//   response by cancelling the remaining beats.
//
// Handshake (cmd channel): a command transfers on a rising HCLK edge where
//   cmd_valid=1 and cmd_ready=1. cmd_ready is high only while the sequencer
//   is idle. cmd_valid may be raised at any time and the command fields must
//   be stable while cmd_valid=1 and cmd_ready=1.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_addr/burst/size/write/len  command fields (len used for INCR only)
//   wdata, wdata_req     write data source; wdata is sampled when wdata_req=1
//   rdata, rdata_valid   registered read data with 1-cycle valid pulse
//   done, done_err       1-cycle completion pulse and error flag
//   HADDR..HBURST        AHB-Lite address/control phase
//   HWDATA, HRDATA       AHB-Lite data buses
//   HREADY, HRESP        AHB-Lite transfer response
//   dbg_state            current FSM state, for observation only
// ---------------------------------------------------------------------------
module ahb_burst_master #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 32
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [2:0]           cmd_burst,
  input  logic [2:0]           cmd_size,
  input  logic                 cmd_write,
  input  logic [4:0]           cmd_len,
  input  logic [DATAWIDTH-1:0] wdata,
  output logic                 wdata_req,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 rdata_valid,
  output logic                 done,
  output logic                 done_err,
  output logic [ADDRWIDTH-1:0] HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic [DATAWIDTH-1:0] HWDATA,
  input  logic [DATAWIDTH-1:0] HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP,
  output logic [2:0]           dbg_state
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  // S_ADDR  : first (NONSEQ) address phase, no data phase in flight
  // S_BURST : SEQ address phase overlapping the previous beat's data phase
  // S_LAST  : data phase of the final beat, bus address phase idle
  // S_ERR   : second cycle of an ERROR response, bus already idle
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_BURST = 3'd2,
    S_LAST  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [4:0] beats_left;   // address phases still to be issued, incl. current
  logic [2:0] inc_q;        // byte increment 1/2/4
  logic       is_wrap_q;
  logic [5:0] wrap_mask;    // wrap boundary - 1 (at most 16 beats * 4 bytes)

  // ---------------- command decode (valid only while idle) ----------------
  logic [4:0] cmd_beats;
  logic [7:0] cmd_bytes;
  logic [2:0] align_mask;
  logic       cmd_cross_1k;
  logic       cmd_reject;
  logic       accept;

  always_comb begin
    cmd_beats = 5'd16;
    case (cmd_burst)
      3'd0:       cmd_beats = 5'd1;
      3'd1:       cmd_beats = (cmd_len == 5'd0) ? 5'd1 : cmd_len;
      3'd2, 3'd3: cmd_beats = 5'd4;
      3'd4, 3'd5: cmd_beats = 5'd8;
      default:    cmd_beats = 5'd16;
    endcase
  end

  always_comb begin
    align_mask = 3'b111;
    case (cmd_size)
      3'd0:    align_mask = 3'b000;
      3'd1:    align_mask = 3'b001;
      3'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  assign cmd_bytes    = {3'b000, cmd_beats} << cmd_size[1:0];
  // The incrementing burst types are exactly the odd HBURST encodings.
  assign cmd_cross_1k = cmd_burst[0] &&
                        (({1'b0, cmd_addr[9:0]} + {3'b000, cmd_bytes}) > 11'h400);
  assign cmd_reject   = (cmd_size > 3'd2) || (|(cmd_addr[2:0] & align_mask)) ||
                        cmd_cross_1k;
  assign accept       = cmd_valid && cmd_ready;

  // ---------------- address generation ----------------
  logic [ADDRWIDTH-1:0] addr_inc;
  logic [ADDRWIDTH-1:0] addr_next;

  assign addr_inc  = HADDR + ADDRWIDTH'(inc_q);
  // Wrap boundary never exceeds 64 bytes, so only the low six bits wrap.
  assign addr_next = is_wrap_q ?
                     {HADDR[ADDRWIDTH-1:6],
                      (HADDR[5:0] & ~wrap_mask) | (addr_inc[5:0] & wrap_mask)} :
                     addr_inc;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid && !cmd_reject) state_d = S_ADDR;
      S_ADDR:  if (HREADY) state_d = (beats_left == 5'd1) ? S_LAST : S_BURST;
      S_BURST: begin
        if (!HREADY && HRESP) state_d = S_ERR;
        else if (HREADY)      state_d = (beats_left == 5'd1) ? S_LAST : S_BURST;
      end
      S_LAST: begin
        if (!HREADY && HRESP) state_d = S_ERR;
        else if (HREADY)      state_d = S_IDLE;
      end
      S_ERR:   if (HREADY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  logic addr_accept;   // address phase of a beat completes this cycle
  logic data_ok;       // data phase completes with OKAY this cycle

  always_comb begin
    cmd_ready   = 1'b0;
    HTRANS      = TRANS_IDLE;
    addr_accept = 1'b0;
    data_ok     = 1'b0;
    case (state_q)
      S_IDLE:  cmd_ready = 1'b1;
      S_ADDR:  begin
        HTRANS      = TRANS_NONSEQ;
        addr_accept = HREADY;
      end
      S_BURST: begin
        HTRANS      = TRANS_SEQ;
        addr_accept = HREADY;
        data_ok     = HREADY && !HRESP;
      end
      S_LAST:  data_ok = HREADY && !HRESP;
      default: ;
    endcase
    wdata_req = addr_accept && HWRITE;
    dbg_state = state_q;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HADDR       <= '0;
      HWRITE      <= 1'b0;
      HSIZE       <= 3'd0;
      HBURST      <= 3'd0;
      HWDATA      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      done_err    <= 1'b0;
      beats_left  <= 5'd0;
      inc_q       <= 3'd0;
      is_wrap_q   <= 1'b0;
      wrap_mask   <= 6'd0;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      done_err    <= 1'b0;

      if (accept) begin
        if (cmd_reject) begin
          done     <= 1'b1;
          done_err <= 1'b1;
        end else begin
          HADDR      <= cmd_addr;
          HWRITE     <= cmd_write;
          HSIZE      <= cmd_size;
          HBURST     <= cmd_burst;
          beats_left <= cmd_beats;
          inc_q      <= 3'd1 << cmd_size[1:0];
          is_wrap_q  <= (cmd_burst != 3'd0) && !cmd_burst[0];
          wrap_mask  <= cmd_bytes[5:0] - 6'd1;
        end
      end

      if (addr_accept) begin
        // Keep the final beat's address on the bus rather than stepping past it.
        if (beats_left != 5'd1) HADDR <= addr_next;
        beats_left <= beats_left - 5'd1;
        if (HWRITE) HWDATA <= wdata;
      end

      if (data_ok && !HWRITE) begin
        rdata       <= HRDATA;
        rdata_valid <= 1'b1;
      end

      if (state_q == S_LAST && HREADY) begin
        done     <= 1'b1;
        done_err <= HRESP;
      end

      if (state_q == S_ERR && HREADY) begin
        done     <= 1'b1;
        done_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_burst_master.sv
module tb_ahb_burst_master;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_burst;
  logic [2:0]  cmd_size;
  logic        cmd_write;
  logic [4:0]  cmd_len;
  logic [31:0] wdata;
  logic        wdata_req;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        done_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic [2:0]  dbg_state;

  ahb_burst_master #(.DATAWIDTH(32), .ADDRWIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_write(cmd_write),
    .cmd_len(cmd_len), .wdata(wdata), .wdata_req(wdata_req),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .done_err(done_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // ---------------- vector table ----------------
  // One row = one clock cycle: inputs driven during the cycle and the
  // outputs expected during that same cycle (before the closing edge).
  typedef struct {
    logic        cv;
    logic [31:0] addr;
    logic [2:0]  burst;
    logic [2:0]  size;
    logic        write;
    logic [4:0]  len;
    logic        rdy;
    logic        rsp;
    logic [31:0] din;     // drives both wdata and HRDATA
    logic [1:0]  e_trans;
    logic [31:0] e_addr;  // checked while HTRANS is expected non-idle
    logic        e_wreq;
    logic        e_rv;
    logic        e_chk;   // check HWDATA (write cmd) or rdata (read cmd)
    logic [31:0] e_data;
    logic        e_done;
    logic        e_err;
    logic        e_crdy;
  } vec_t;

  vec_t tab[$];

  logic [31:0] c_addr;
  logic [2:0]  c_burst;
  logic [2:0]  c_size;
  logic        c_write;
  logic [4:0]  c_len;

  int n_vec  = 0;
  int n_miss = 0;
  int cur_row = 0;

  task automatic set_cmd(input logic [31:0] a, input logic [2:0] b,
                         input logic [2:0] s, input logic w, input logic [4:0] l);
    c_addr = a; c_burst = b; c_size = s; c_write = w; c_len = l;
  endtask

  task automatic row(input logic cv, input logic rdy, input logic rsp,
                     input logic [31:0] din, input logic [1:0] et,
                     input logic [31:0] ea, input logic ew, input logic erv,
                     input logic ec, input logic [31:0] ed,
                     input logic edn, input logic eer, input logic ecr);
    vec_t v;
    v.cv = cv; v.addr = c_addr; v.burst = c_burst; v.size = c_size;
    v.write = c_write; v.len = c_len; v.rdy = rdy; v.rsp = rsp; v.din = din;
    v.e_trans = et; v.e_addr = ea; v.e_wreq = ew; v.e_rv = erv;
    v.e_chk = ec; v.e_data = ed; v.e_done = edn; v.e_err = eer; v.e_crdy = ecr;
    tab.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, cur_row, act, exp);
    end
  endtask

  // Called at posedge+1; checks at posedge+2; returns at next posedge+1.
  task automatic apply(input vec_t v);
    cmd_valid = v.cv; cmd_addr = v.addr; cmd_burst = v.burst; cmd_size = v.size;
    cmd_write = v.write; cmd_len = v.len;
    wdata = v.din; HRDATA = v.din; HREADY = v.rdy; HRESP = v.rsp;
    #1;
    chk("htrans", 32'(HTRANS), 32'(v.e_trans));
    if (v.e_trans != T_IDLE) chk("haddr", HADDR, v.e_addr);
    chk("wdata_req", 32'(wdata_req), 32'(v.e_wreq));
    chk("rdata_valid", 32'(rdata_valid), 32'(v.e_rv));
    chk("done", 32'(done), 32'(v.e_done));
    chk("done_err", 32'(done_err), 32'(v.e_err));
    chk("cmd_ready", 32'(cmd_ready), 32'(v.e_crdy));
    if (v.e_chk) begin
      if (v.write) chk("hwdata", HWDATA, v.e_data);
      else         chk("rdata", rdata, v.e_data);
    end
    @(posedge HCLK); #1;
  endtask

  initial begin
    // ---------------- stimulus table ----------------
    // WRITE SINGLE WORD @0x100
    set_cmd(32'h100, 3'd0, 3'd2, 1'b1, 5'd0);
    row(1,1,0,32'h0,        T_IDLE,32'h0,   0,0,0,32'h0,        0,0,1);
    row(0,1,0,32'hA5A50001, T_NSEQ,32'h100, 1,0,0,32'h0,        0,0,0);
    row(0,1,0,32'h0,        T_IDLE,32'h0,   0,0,1,32'hA5A50001, 0,0,0);
    row(0,1,0,32'h0,        T_IDLE,32'h0,   0,0,1,32'hA5A50001, 1,0,1);
    row(0,1,0,32'h0,        T_IDLE,32'h0,   0,0,0,32'h0,        0,0,1);
    // READ WRAP4 WORD @0x38
    set_cmd(32'h38, 3'd2, 3'd2, 1'b0, 5'd0);
    row(1,1,0,32'h0,        T_IDLE,32'h0,  0,0,0,32'h0,        0,0,1);
    row(0,1,0,32'h0,        T_NSEQ,32'h38, 0,0,0,32'h0,        0,0,0);
    row(0,1,0,32'hD0D0D0D0, T_SEQ, 32'h3C, 0,0,0,32'h0,        0,0,0);
    row(0,1,0,32'hD1D1D1D1, T_SEQ, 32'h30, 0,1,1,32'hD0D0D0D0, 0,0,0);
    row(0,1,0,32'hD2D2D2D2, T_SEQ, 32'h34, 0,1,1,32'hD1D1D1D1, 0,0,0);
    row(0,1,0,32'hD3D3D3D3, T_IDLE,32'h0,  0,1,1,32'hD2D2D2D2, 0,0,0);
    row(0,1,0,32'h0,        T_IDLE,32'h0,  0,1,1,32'hD3D3D3D3, 1,0,1);
    row(0,1,0,32'h0,        T_IDLE,32'h0,  0,0,0,32'h0,        0,0,1);
    // WRITE INCR8 HALFWORD @0x200, two wait states on the third beat
    set_cmd(32'h200, 3'd5, 3'd1, 1'b1, 5'd0);
    row(1,1,0,32'h0,    T_IDLE,32'h0,   0,0,0,32'h0,    0,0,1);
    row(0,1,0,32'h1000, T_NSEQ,32'h200, 1,0,0,32'h0,    0,0,0);
    row(0,1,0,32'h1001, T_SEQ, 32'h202, 1,0,1,32'h1000, 0,0,0);
    row(0,0,0,32'h1002, T_SEQ, 32'h204, 0,0,1,32'h1001, 0,0,0);
    row(0,0,0,32'h1002, T_SEQ, 32'h204, 0,0,1,32'h1001, 0,0,0);
    row(0,1,0,32'h1002, T_SEQ, 32'h204, 1,0,1,32'h1001, 0,0,0);
    row(0,1,0,32'h1003, T_SEQ, 32'h206, 1,0,1,32'h1002, 0,0,0);
    row(0,1,0,32'h1004, T_SEQ, 32'h208, 1,0,1,32'h1003, 0,0,0);
    row(0,1,0,32'h1005, T_SEQ, 32'h20A, 1,0,1,32'h1004, 0,0,0);
    row(0,1,0,32'h1006, T_SEQ, 32'h20C, 1,0,1,32'h1005, 0,0,0);
    row(0,1,0,32'h1007, T_SEQ, 32'h20E, 1,0,1,32'h1006, 0,0,0);
    row(0,1,0,32'h0,    T_IDLE,32'h0,   0,0,1,32'h1007, 0,0,0);
    row(0,1,0,32'h0,    T_IDLE,32'h0,   0,0,1,32'h1007, 1,0,1);
    // READ INCR4 WORD @0x10, ERROR on the second beat's data phase
    set_cmd(32'h10, 3'd3, 3'd2, 1'b0, 5'd0);
    row(1,1,0,32'h0,        T_IDLE,32'h0,  0,0,0,32'h0,        0,0,1);
    row(0,1,0,32'h0,        T_NSEQ,32'h10, 0,0,0,32'h0,        0,0,0);
    row(0,1,0,32'hBEEF0001, T_SEQ, 32'h14, 0,0,0,32'h0,        0,0,0);
    row(0,0,1,32'hDEAD0002, T_SEQ, 32'h18, 0,1,1,32'hBEEF0001, 0,0,0);
    row(0,1,1,32'hDEAD0002, T_IDLE,32'h0,  0,0,0,32'h0,        0,0,0);
    row(0,1,0,32'h0,        T_IDLE,32'h0,  0,0,0,32'h0,        1,1,1);
    row(0,1,0,32'h0,        T_IDLE,32'h0,  0,0,0,32'h0,        0,0,1);
    // Rejects: misaligned WORD, INCR4 crossing 1KB, illegal size
    set_cmd(32'h102, 3'd0, 3'd2, 1'b1, 5'd0);
    row(1,1,0,32'h0, T_IDLE,32'h0, 0,0,0,32'h0, 0,0,1);
    row(0,1,0,32'h0, T_IDLE,32'h0, 0,0,0,32'h0, 1,1,1);
    row(0,1,0,32'h0, T_IDLE,32'h0, 0,0,0,32'h0, 0,0,1);
    set_cmd(32'h3F8, 3'd3, 3'd2, 1'b0, 5'd0);
    row(1,1,0,32'h0, T_IDLE,32'h0, 0,0,0,32'h0, 0,0,1);
    row(0,1,0,32'h0, T_IDLE,32'h0, 0,0,0,32'h0, 1,1,1);
    row(0,1,0,32'h0, T_IDLE,32'h0, 0,0,0,32'h0, 0,0,1);
    set_cmd(32'h0, 3'd0, 3'd3, 1'b0, 5'd0);
    row(1,1,0,32'h0, T_IDLE,32'h0, 0,0,0,32'h0, 0,0,1);
    row(0,1,0,32'h0, T_IDLE,32'h0, 0,0,0,32'h0, 1,1,1);
    row(0,1,0,32'h0, T_IDLE,32'h0, 0,0,0,32'h0, 0,0,1);
    // READ INCR with cmd_len=0 behaves as one beat
    set_cmd(32'h40, 3'd1, 3'd2, 1'b0, 5'd0);
    row(1,1,0,32'h0,        T_IDLE,32'h0,  0,0,0,32'h0,        0,0,1);
    row(0,1,0,32'h0,        T_NSEQ,32'h40, 0,0,0,32'h0,        0,0,0);
    row(0,1,0,32'h77665544, T_IDLE,32'h0,  0,0,0,32'h0,        0,0,0);
    row(0,1,0,32'h0,        T_IDLE,32'h0,  0,1,1,32'h77665544, 1,0,1);

    // ---------------- reset ----------------
    HRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_burst = '0; cmd_size = '0;
    cmd_write = 1'b0; cmd_len = '0; wdata = '0; HRDATA = '0;
    HREADY = 1'b1; HRESP = 1'b0;
    #12;
    chk("rst_htrans", 32'(HTRANS), 32'(T_IDLE));
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwrite", 32'(HWRITE), 32'h0);
    chk("rst_hsize", 32'(HSIZE), 32'h0);
    chk("rst_hburst", 32'(HBURST), 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'h0);
    chk("rst_wdata_req", 32'(wdata_req), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_done_err", 32'(done_err), 32'h0);
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // ---------------- table loop ----------------
    for (int i = 0; i < tab.size(); i++) begin
      cur_row = i;
      apply(tab[i]);
    end

    // ---------------- reset during INCR16 beat 5 ----------------
    cur_row = -1;
    cmd_valid = 1'b1; cmd_addr = 32'h80; cmd_burst = 3'd7; cmd_size = 3'd2;
    cmd_write = 1'b1; cmd_len = 5'd0; wdata = 32'hC0DE0000; HREADY = 1'b1; HRESP = 1'b0;
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("i16_htrans", 32'(HTRANS), (k == 1) ? 32'(T_NSEQ) : 32'(T_SEQ));
      chk("i16_haddr", HADDR, 32'h80 + 32'(4 * (k - 1)));
      if (k < 5) begin @(posedge HCLK); #1; end
    end
    #1 HRESETn = 1'b0;
    #1;
    chk("arst_htrans", 32'(HTRANS), 32'(T_IDLE));
    chk("arst_haddr", HADDR, 32'h0);
    chk("arst_hwdata", HWDATA, 32'h0);
    chk("arst_wdata_req", 32'(wdata_req), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    @(negedge HCLK); @(negedge HCLK); HRESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge HCLK); #1;
      chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);
      chk("post_rst_htrans", 32'(HTRANS), 32'(T_IDLE));
      chk("post_rst_done", 32'(done), 32'h0);
    end

    // A fresh SINGLE read runs normally after the reset.
    cmd_valid = 1'b1; cmd_addr = 32'h44; cmd_burst = 3'd0; cmd_size = 3'd2; cmd_write = 1'b0;
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
    #1;
    chk("post_rst_nseq", 32'(HTRANS), 32'(T_NSEQ));
    chk("post_rst_haddr", HADDR, 32'h44);
    @(posedge HCLK); #1;
    HRDATA = 32'h12345678;
    @(posedge HCLK); #1;
    chk("post_rst_rv", 32'(rdata_valid), 32'h1);
    chk("post_rst_rdata", rdata, 32'h12345678);
    chk("post_rst_done", 32'(done), 32'h1);
    chk("post_rst_done_err", 32'(done_err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
